// File: rtl/traffic_pkg.sv
// Shared light encoding and queue-capacity derivation for the traffic lane model.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        RED    = 2'd2
    } light_e;

    // Gap counter width; covers the largest legal DEPART_GAP of 15.
    localparam int GAP_W = 4;

    function automatic int qmax_of(input int qw);
        return (2 ** qw) - 1;
    endfunction

endpackage

// File: rtl/lane_queue.sv
// One lane: waiting-car count, inter-departure gap timer and sticky drop flag.
module lane_queue
    import traffic_pkg::*;
#(
    parameter int QW         = 4,
    parameter int DEPART_GAP = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    light_i,
    input  logic          arr_i,
    output logic [QW-1:0] cnt_o,
    output logic          drop_o
);

    localparam logic [QW-1:0]    QMAX     = QW'(qmax_of(QW));
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(DEPART_GAP - 1);

    logic [QW-1:0]    cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             drop_q, drop_d;
    logic             green;
    logic             depart;

    assign green  = (light_i == GREEN);
    assign depart = green && (cnt_q != '0) && (gap_q == '0);

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves it unassigned and no latch is inferred.
        cnt_d  = cnt_q;
        gap_d  = gap_q;
        drop_d = drop_q;

        if (!green)
            gap_d = '0;
        else if (depart)
            gap_d = GAP_LOAD;
        else if (gap_q != '0)
            gap_d = gap_q - 1'b1;

        // Arrival and departure in the same cycle cancel out.
        if (arr_i && !depart) begin
            if (cnt_q == QMAX)
                drop_d = 1'b1;
            else
                cnt_d = cnt_q + 1'b1;
        end else if (depart && !arr_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            gap_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gap_q  <= gap_d;
            drop_q <= drop_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign drop_o = drop_q;

endmodule

// File: rtl/traffic_lane_model.sv
// Two-lane intersection queue model; the optional conflict_err safety monitor
// is built only when TRAFFIC_SAFETY_CHECK_EN is defined.
module traffic_lane_model
    import traffic_pkg::*;
#(
    parameter int QW         = 4,
    parameter int DEPART_GAP = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    La,
    input  logic [1:0]    Lb,
    input  logic          arr_a,
    input  logic          arr_b,
    output logic          Ta,
    output logic          Tb,
    output logic [QW-1:0] qa_cnt,
    output logic [QW-1:0] qb_cnt,
    output logic          drop_a,
    output logic          drop_b
`ifdef TRAFFIC_SAFETY_CHECK_EN
    ,
    output logic          conflict_err
`endif
);

    lane_queue #(.QW(QW), .DEPART_GAP(DEPART_GAP)) u_lane_a (
        .clk     (clk),
        .rst     (rst),
        .light_i (La),
        .arr_i   (arr_a),
        .cnt_o   (qa_cnt),
        .drop_o  (drop_a)
    );

    lane_queue #(.QW(QW), .DEPART_GAP(DEPART_GAP)) u_lane_b (
        .clk     (clk),
        .rst     (rst),
        .light_i (Lb),
        .arr_i   (arr_b),
        .cnt_o   (qb_cnt),
        .drop_o  (drop_b)
    );

    assign Ta = (qa_cnt != '0);
    assign Tb = (qb_cnt != '0);

`ifdef TRAFFIC_SAFETY_CHECK_EN
    logic conflict_q;
    logic hazard;

    // Both directions open at once, or a light showing the illegal code.
    assign hazard = ((La != RED) && (Lb != RED)) || (La == 2'd3) || (Lb == 2'd3);

    always_ff @(posedge clk) begin
        if (rst)
            conflict_q <= 1'b0;
        else if (hazard)
            conflict_q <= 1'b1;
    end

    assign conflict_err = conflict_q;
`endif

endmodule

// File: tb/tb_traffic_lane_model.sv
// Randomized self-checking bench: two DUTs (QW=4 and QW=2) against a
// cycle-count based reference model of queue, spacing and drop rules.
module tb_traffic_lane_model;

    localparam int GAP = 3;
    localparam logic [1:0] G = 2'd0, Y = 2'd1, R = 2'd2, X = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] La, Lb;
    logic       arr_a, arr_b;

    logic       ta0, tb0, da0, db0;
    logic [3:0] qa0, qb0;
    logic       ta1, tb1, da1, db1;
    logic [1:0] qa1, qb1;
`ifdef TRAFFIC_SAFETY_CHECK_EN
    logic       ce0, ce1;
`endif

    traffic_lane_model #(.QW(4), .DEPART_GAP(GAP)) dut (
        .clk(clk), .rst(rst), .La(La), .Lb(Lb), .arr_a(arr_a), .arr_b(arr_b),
        .Ta(ta0), .Tb(tb0), .qa_cnt(qa0), .qb_cnt(qb0), .drop_a(da0), .drop_b(db0)
`ifdef TRAFFIC_SAFETY_CHECK_EN
        , .conflict_err(ce0)
`endif
    );

    traffic_lane_model #(.QW(2), .DEPART_GAP(GAP)) dut_small (
        .clk(clk), .rst(rst), .La(La), .Lb(Lb), .arr_a(arr_a), .arr_b(arr_b),
        .Ta(ta1), .Tb(tb1), .qa_cnt(qa1), .qb_cnt(qb1), .drop_a(da1), .drop_b(db1)
`ifdef TRAFFIC_SAFETY_CHECK_EN
        , .conflict_err(ce1)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed === expected)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    endtask

    // Reference model. Lanes: 0=A big, 1=B big, 2=A small, 3=B small.
    int cyc = 0;
    int m_cnt[4];
    bit m_drop[4];
    int last_dep[4];
    int last_red[4];
    bit m_conf;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i]    = 0;
            m_drop[i]   = 0;
            last_dep[i] = -1000;
            last_red[i] = -1000;
        end
        m_conf = 0;
    endtask

    // A car may leave on green once GAP edges have passed since the previous
    // departure, or once the light has been off green at any edge since then.
    task automatic model_lane(input int i, input logic [1:0] light, input logic arr, input int qmax);
        bit green = (light == G);
        bit ready = ((cyc - last_dep[i]) >= GAP) || (last_red[i] > last_dep[i]);
        bit dep   = green && (m_cnt[i] > 0) && ready;
        if (dep)    last_dep[i] = cyc;
        if (!green) last_red[i] = cyc;
        if (arr && !dep) begin
            if (m_cnt[i] == qmax) m_drop[i] = 1;
            else                  m_cnt[i]++;
        end else if (dep && !arr) begin
            m_cnt[i]--;
        end
    endtask

    task automatic compare_all();
        check("qa_cnt",   qa0, m_cnt[0]);
        check("qb_cnt",   qb0, m_cnt[1]);
        check("Ta",       ta0, m_cnt[0] != 0);
        check("Tb",       tb0, m_cnt[1] != 0);
        check("drop_a",   da0, m_drop[0]);
        check("drop_b",   db0, m_drop[1]);
        check("s_qa_cnt", qa1, m_cnt[2]);
        check("s_qb_cnt", qb1, m_cnt[3]);
        check("s_Ta",     ta1, m_cnt[2] != 0);
        check("s_Tb",     tb1, m_cnt[3] != 0);
        check("s_drop_a", da1, m_drop[2]);
        check("s_drop_b", db1, m_drop[3]);
`ifdef TRAFFIC_SAFETY_CHECK_EN
        check("conflict_err",   ce0, m_conf);
        check("s_conflict_err", ce1, m_conf);
`endif
    endtask

    task automatic step(input logic [1:0] la, input logic [1:0] lb,
                        input logic aa, input logic ab, input logic r);
        La = la; Lb = lb; arr_a = aa; arr_b = ab; rst = r;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            model_lane(0, la, aa, 15);
            model_lane(1, lb, ab, 15);
            model_lane(2, la, aa, 3);
            model_lane(3, lb, ab, 3);
            if (((la != R) && (lb != R)) || (la == X) || (lb == X)) m_conf = 1;
        end
        cyc++;
        #1;
        compare_all();
    endtask

    initial begin
        int e34[7];
        int e35[7];
        logic [1:0] rla, rlb;
        e34 = '{2, 2, 2, 1, 1, 1, 0};
        e35 = '{2, 3, 4, 4, 5, 6, 6};
        model_reset();

        // Reset for two cycles, then three arrivals on red.
        step(R, R, 0, 0, 1);
        step(R, R, 0, 0, 1);
        check("reset_qa", qa0, 0);
        check("reset_Ta", ta0, 0);
        repeat (3) step(R, R, 1, 0, 0);
        check("red_fill_qa", qa0, 3);
        check("red_fill_Ta", ta0, 1);
        check("red_fill_Tb", tb0, 0);

        // Green with gap 3: departures at green edges 0, 3 and 6.
        for (int k = 0; k < 7; k++) begin
            step(G, R, 0, 0, 0);
            check("gap_qa", qa0, e34[k]);
        end
        check("drain_Ta", ta0, 0);

        // Continuous arrivals on green: departures cancel arrivals.
        step(R, R, 0, 0, 1);
        repeat (2) step(R, R, 1, 0, 0);
        for (int k = 0; k < 7; k++) begin
            step(G, R, 1, 0, 0);
            check("arr_on_green_qa", qa0, e35[k]);
        end

        // Saturation of the QW=2 lane B, then drain; drop stays sticky.
        step(R, R, 0, 0, 1);
        repeat (4) step(R, R, 0, 1, 0);
        check("sat_qb", qb1, 3);
        check("sat_drop_b", db1, 1);
        repeat (10) step(R, G, 0, 0, 0);
        check("sat_drained_qb", qb1, 0);
        check("sat_drop_sticky", db1, 1);

        // Reset in the middle of green with five cars queued.
        step(R, R, 0, 0, 1);
        repeat (5) step(R, R, 1, 0, 0);
        step(G, R, 0, 0, 0);
        step(G, R, 0, 0, 1);
        check("midrst_qa", qa0, 0);
        check("midrst_Ta", ta0, 0);
        check("midrst_drop_a", da0, 0);

        // Randomized traffic; green and red are favoured over yellow and 3.
        for (int n = 0; n < 400; n++) begin
            int p;
            p = $urandom_range(0, 9);
            rla = (p < 4) ? G : (p < 8) ? R : (p < 9) ? Y : X;
            p = $urandom_range(0, 9);
            rlb = (p < 4) ? G : (p < 8) ? R : (p < 9) ? Y : X;
            step(rla, rlb, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 199) == 0));
        end

`ifdef TRAFFIC_SAFETY_CHECK_EN
        step(R, R, 0, 0, 1);
        step(G, Y, 0, 0, 0);
        check("conflict_set", ce0, 1);
        repeat (3) step(R, R, 0, 0, 0);
        check("conflict_held", ce0, 1);
        step(R, R, 0, 0, 1);
        check("conflict_rst", ce0, 0);
        step(X, R, 0, 0, 0);
        check("conflict_illegal", ce0, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/traffic_lane_model.md
TRAFFIC_LANE_MODEL -- requirements
Module: traffic_lane_model

Interface
REQ-001 SHALL have parameter QW, default 4: queue counter width; capacity QMAX = 2**QW-1.
REQ-002 SHALL have parameter DEPART_GAP, default 3: minimum cycles between departures in one lane (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port La  input  2  north-south light (green=0, yellow=1, red=2, 3=illegal).
REQ-006 SHALL have port Lb  input  2  east-west light, same encoding as La.
REQ-007 SHALL have port arr_a  input  1  one car arrives at lane A this cycle.
REQ-008 SHALL have port arr_b  input  1  one car arrives at lane B this cycle.
REQ-009 SHALL have port Ta  output  1  lane A sensor: high when qa_cnt != 0.
REQ-010 SHALL have port Tb  output  1  lane B sensor: high when qb_cnt != 0.
REQ-011 SHALL have port qa_cnt  output  QW  cars waiting in lane A.
REQ-012 SHALL have port qb_cnt  output  QW  cars waiting in lane B.
REQ-013 SHALL have port drop_a, drop_b  output  1 each  sticky: an arrival was lost at full queue.
REQ-014 SHALL have port conflict_err  output  1  sticky safety flag (present only per REQ-030).

Function
REQ-015 SHALL decode Ta/Tb combinationally from the registered counts; Ta/Tb rise the cycle after the first arrival edge.
REQ-016 SHALL treat each lane independently using the lane's own light (lane A uses La, lane B uses Lb).
REQ-017 SHALL keep a per-lane gap counter; when the light is not green, the gap counter is forced to 0.
REQ-018 SHALL depart one car at an edge when light==green, count>0 and gap==0; gap then loads DEPART_GAP-1.
REQ-019 SHALL decrement gap each cycle while gap>0, regardless of count.
REQ-020 SHALL NOT depart cars on yellow, red or illegal encoding 3.
REQ-021 SHALL increment count on arrival only, decrement on departure only, and leave it unchanged on simultaneous arrival and departure.
REQ-022 SHALL saturate at QMAX: an arrival with no simultaneous departure at count==QMAX leaves count unchanged and sets drop_x.
REQ-023 SHALL never underflow: no departure at count==0.
REQ-024 SHALL hold drop_x set until reset.

Reset
REQ-025 SHALL on rst clear qa_cnt, qb_cnt, gap counters, drop_a, drop_b and conflict_err to 0, so Ta=Tb=0.
REQ-026 SHALL give rst priority over arrivals and departures in the same cycle.
REQ-027 SHALL on reset mid-operation discard all queued cars and restart with no departures until a fresh green with gap==0.

Configuration
REQ-028 SHALL use macro TRAFFIC_SAFETY_CHECK_EN.
REQ-029 SHALL without TRAFFIC_SAFETY_CHECK_EN omit conflict_err and all check logic.
REQ-030 SHALL with TRAFFIC_SAFETY_CHECK_EN set conflict_err at the edge after any cycle where La!=red and Lb!=red, or either light ==3; the flag is sticky until rst.

Structure
REQ-031 SHALL take the colors enum (green, yellow, red) and the QMAX derivation from shared package traffic_pkg.
REQ-032 SHALL implement one lane (count, gap, departure, drop) as sub-module lane_queue, instantiated twice.

Verification
REQ-033 SHALL check: rst high 2 cycles, then La=Lb=red, arr_a pulses 3 cycles -> qa_cnt=3, Ta=1, Tb=0, no departures.
REQ-034 SHALL check: qa_cnt=3, La=green with DEPART_GAP=3 -> departures at green edges 0, 3 and 6; qa_cnt=0 and Ta=0 after edge 6.
REQ-035 SHALL check: La=green, qa_cnt=2, arr_a high every cycle -> count stays at 2 on departure edges and increments on the others.
REQ-036 SHALL check: QW=2 with 4 arrivals on red -> qb_cnt=3, drop_b=1; drop_b stays 1 after the queue drains.
REQ-037 SHALL check: qa_cnt=5, assert rst for one cycle mid-green -> qa_cnt=0, Ta=0, drop_a=0 on the next cycle.
REQ-038 SHALL check, with TRAFFIC_SAFETY_CHECK_EN: La=green and Lb=yellow for 1 cycle -> conflict_err=1 next edge and held; La=3 also sets it.
